// File: rtl/text_scroller_if.sv
// Character input stream and display outputs of text_scroller_gen.
interface text_scroller_if #(
    parameter int unsigned DISP_CHARS = 16,
    parameter int unsigned ADDR_W     = 11
) ();
    logic [7:0]              ascii_data;
    logic                    ascii_data_ready;
    logic [1:0]              mode;
    logic                    pause;
    logic [8*DISP_CHARS-1:0] string_data;
    logic [ADDR_W:0]         msg_len;
    logic                    busy;
    logic                    overflow;

    modport master (
        output ascii_data, ascii_data_ready, mode, pause,
        input  string_data, msg_len, busy, overflow
    );

    modport slave (
        input  ascii_data, ascii_data_ready, mode, pause,
        output string_data, msg_len, busy, overflow
    );
endinterface

// File: rtl/text_scroller_gen.sv
// Stores a framed character message and presents a DISP_CHARS-wide window of it,
// scrolling in static, wrap or bounce mode with per-position dwell times.
module text_scroller_gen #(
    parameter int unsigned DISP_CHARS = 16,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned SPEED_CNT  = 9000000,
    parameter int unsigned BEGIN_CNT  = 27000000,
    parameter int unsigned END_CNT    = 27000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic           clk,
    input  logic           reset,
    text_scroller_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned IDX_W = $clog2(DISP_CHARS);
    localparam int unsigned STR_W = 8 * DISP_CHARS;
    localparam int unsigned SHD_W = STR_W - 8;
    localparam int unsigned SH_W  = (SHD_W > 8) ? $clog2(SHD_W) : 3;
    localparam logic [7:0]       SPACE = 8'h20;
    localparam logic [STR_W-1:0] BLANK = {DISP_CHARS{SPACE}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic               busy_q;
    logic               ready_q;
    logic [IDX_W-1:0]   fetch_idx_q;
    logic               rd_valid_q;
    logic [IDX_W-1:0]   rd_slot_q;
    logic               rd_blank_q;
    logic [7:0]         rd_data_q;
    logic [SHD_W-1:0]   shadow_q;
    logic [STR_W-1:0]   string_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic [LEN_W-1:0]   pos_q;
    logic               dir_q;
    logic [CNT_W-1:0]   timer_q;
    logic [7:0]         mem [DEPTH];

    logic               ready;
    logic               frame_start_c, frame_end_c;
    logic [LEN_W-1:0]   last_pos_c;
    logic [LEN_W-1:0]   slot_addr_c;
    logic               commit_c;
    logic [7:0]         rd_char_c;
    logic [SH_W-1:0]    slot_lsb_c;
    logic               timer_en_c;
    logic [CNT_W-1:0]   limit_c;
    logic               tick_c;
    logic [LEN_W-1:0]   next_pos_c;
    logic               next_dir_c;
    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_wa_c;

    assign ready         = bus.ascii_data_ready;
    assign frame_start_c = ready & ~ready_q;
    assign frame_end_c   = ~ready & ready_q;
    assign last_pos_c    = (len_q > LEN_W'(DISP_CHARS)) ? len_q - LEN_W'(DISP_CHARS) : '0;
    assign slot_addr_c   = pos_q + LEN_W'(fetch_idx_q);
    assign commit_c      = rd_valid_q && (rd_slot_q == IDX_W'(DISP_CHARS - 1));
    assign rd_char_c     = rd_blank_q ? SPACE : rd_data_q;
    assign slot_lsb_c    = SH_W'((DISP_CHARS - 2 - 32'(rd_slot_q)) * 8);

    // Timer runs only in a settled, non-frame, unpaused state with somewhere to scroll.
    assign timer_en_c = ~ready & ~ready_q & (state_q == S_IDLE) & ~bus.pause
                      & (last_pos_c != '0);
    assign limit_c    = (pos_q == '0)         ? CNT_W'(BEGIN_CNT) :
                        (pos_q == last_pos_c) ? CNT_W'(END_CNT)   : CNT_W'(SPEED_CNT);
    assign tick_c     = timer_en_c && (timer_q == limit_c - CNT_W'(1));

    assign mem_we_c = ~reset & ready & (frame_start_c | (len_q != LEN_W'(DEPTH)));
    assign mem_wa_c = frame_start_c ? '0 : len_q[ADDR_W-1:0];

    // Next scroll position; mode is only consulted here, i.e. at ticks.
    always_comb begin
        next_pos_c = '0;
        next_dir_c = 1'b1;
        case (bus.mode)
            2'b01: begin
                next_pos_c = (pos_q >= last_pos_c) ? '0 : pos_q + LEN_W'(1);
                next_dir_c = dir_q;
            end
            2'b10: begin
                if ((dir_q && (pos_q < last_pos_c)) || (pos_q == '0))
                    next_pos_c = pos_q + LEN_W'(1);
                else
                    next_pos_c = pos_q - LEN_W'(1);
                if (next_pos_c >= last_pos_c)
                    next_dir_c = 1'b0;
                else if (next_pos_c == '0)
                    next_dir_c = 1'b1;
                else
                    next_dir_c = (next_pos_c > pos_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_end_c || tick_c) state_d = S_FETCH;
            S_FETCH: if (fetch_idx_q == IDX_W'(DISP_CHARS - 1)) state_d = S_DRAIN;
            S_DRAIN: if (commit_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ready) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_wa_c] <= bus.ascii_data;
        rd_data_q <= mem[slot_addr_c[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            fetch_idx_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_slot_q   <= '0;
            rd_blank_q  <= 1'b0;
            shadow_q    <= '0;
            string_q    <= BLANK;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            ready_q     <= ready;
            fetch_idx_q <= (state_q == S_FETCH && state_d == S_FETCH) ? fetch_idx_q + IDX_W'(1) : '0;
            rd_valid_q  <= (state_q == S_FETCH) & ~ready;
            rd_slot_q   <= fetch_idx_q;
            rd_blank_q  <= (slot_addr_c >= len_q);

            // The final slot bypasses the shadow and lands directly in the display word.
            if (rd_valid_q && !commit_c) shadow_q[slot_lsb_c +: 8] <= rd_char_c;

            if (ready)
                string_q <= BLANK;
            else if (commit_c)
                string_q <= {shadow_q, rd_char_c};

            if (frame_start_c) begin
                len_q <= LEN_W'(1);
                ovf_q <= 1'b0;
                pos_q <= '0;
                dir_q <= 1'b1;
            end else if (ready) begin
                if (len_q == LEN_W'(DEPTH)) ovf_q <= 1'b1;
                else                        len_q <= len_q + LEN_W'(1);
            end else if (tick_c) begin
                pos_q <= next_pos_c;
                dir_q <= next_dir_c;
            end

            if (ready || tick_c)
                timer_q <= '0;
            else if (timer_en_c)
                timer_q <= timer_q + CNT_W'(1);
        end
    end

    assign bus.string_data = string_q;
    assign bus.msg_len     = len_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_text_scroller_gen.sv
// Self-checking bench for text_scroller_gen: vector table, directed scroll sequences
// and randomized messages against a position/window reference model.
module tb_text_scroller_gen;
    localparam int unsigned DISP  = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SPD   = 20;
    localparam int unsigned BEG   = 40;
    localparam int unsigned ENDC  = 30;
    localparam int unsigned CW    = 8;
    localparam logic [31:0] BLANK = 32'h20202020;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    text_scroller_if #(.DISP_CHARS(DISP), .ADDR_W(AW)) bus ();

    text_scroller_gen #(
        .DISP_CHARS(DISP), .ADDR_W(AW), .SPEED_CNT(SPD),
        .BEGIN_CNT(BEG), .END_CNT(ENDC), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       msg;
        logic [1:0]  mode;
        int          exp_len;
        logic        exp_ovf;
        logic [31:0] disp0;
        logic        exp_step;
        int          dwell1;
        logic [31:0] disp1;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [31:0] window(input string m, input int pos);
        logic [31:0] w;
        int n;
        int idx;
        n = (m.len() > DEPTH) ? DEPTH : m.len();
        w = '0;
        for (int k = 0; k < DISP; k++) begin
            idx = pos + k;
            w[31-8*k -: 8] = (idx < n) ? m[idx] : 8'h20;
        end
        return w;
    endfunction

    function automatic int last_of(input int len);
        return (len > DISP) ? len - DISP : 0;
    endfunction

    function automatic int pos_at(input logic [1:0] mode, input int last, input int k);
        int p;
        case (mode)
            2'b01: return k % (last + 1);
            2'b10: begin
                p = k % (2 * last);
                return (p <= last) ? p : 2 * last - p;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int limit_of(input int pos, input int last);
        if (pos == 0)    return BEG;
        if (pos == last) return ENDC;
        return SPD;
    endfunction

    function automatic vec_t mk(input string msg, input logic [1:0] mode, input int len,
                                input logic ovf, input logic [31:0] d0, input logic step,
                                input int dw, input logic [31:0] d1);
        vec_t v;
        v.msg = msg; v.mode = mode; v.exp_len = len; v.exp_ovf = ovf;
        v.disp0 = d0; v.exp_step = step; v.dwell1 = dw; v.disp1 = d1;
        return v;
    endfunction

    // ---- stimulus helpers ----
    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.ascii_data       = s[i];
            bus.ascii_data_ready = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                check("frame_start_len",   bus.msg_len, 1);
                check("frame_start_ovf",   bus.overflow, 0);
                check("frame_start_blank", bus.string_data, BLANK);
            end
        end
        bus.ascii_data_ready = 1'b0;
    endtask

    task automatic wait_commit(output int cyc, output logic [31:0] disp);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) seen = 1'b1;
            else if (seen) break;
        end
        disp = bus.string_data;
    endtask

    // Counts busy-low cycles until the next refresh, then waits for its commit.
    task automatic next_step(input int pause_at, input int pause_len,
                             output int dwell, output logic [31:0] disp);
        int cyc;
        dwell = 0;
        while (!bus.busy && dwell < 400) begin
            if (dwell == pause_at) begin
                bus.pause = 1'b1;
                repeat (pause_len) begin
                    @(negedge clk);
                    dwell++;
                end
                bus.pause = 1'b0;
            end
            @(negedge clk);
            dwell++;
        end
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("refresh_end", bus.busy, 0);
        disp = bus.string_data;
    endtask

    task automatic quiet(input int n, input logic [31:0] disp, input string name);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.busy) hits++;
        end
        check({name, "_busy"}, hits, 0);
        check({name, "_disp"}, bus.string_data, disp);
    endtask

    task automatic start_msg(input string s, input logic [1:0] mode, input string name);
        int cyc;
        logic [31:0] d;
        bus.mode = mode;
        send_frame(s);
        wait_commit(cyc, d);
        check({name, "_latency_ok"}, (cyc <= 6), 1);
        check({name, "_disp0"}, d, window(s, 0));
    endtask

    task automatic run_seq(input string name, input logic [31:0] exp_d[], input int exp_dw[]);
        int dw;
        logic [31:0] d;
        for (int i = 0; i < exp_dw.size(); i++) begin
            next_step(-1, 0, dw, d);
            check({name, "_dwell"}, dw, exp_dw[i]);
            check({name, "_disp"}, d, exp_d[i]);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int          dw, cyc, len, last, pos, prev;
        logic [31:0] d;
        logic [1:0]  m;
        string       base, s;

        vecs[0] = mk("ABCDEF",     2'b01, 6, 1'b0, "ABCD", 1'b1, 40, "BCDE");
        vecs[1] = mk("HI",         2'b00, 2, 1'b0, "HI  ", 1'b0, 0,  "HI  ");
        vecs[2] = mk("ABCDEFGHIJ", 2'b01, 8, 1'b1, "ABCD", 1'b1, 40, "BCDE");
        vecs[3] = mk("WXYZ",       2'b10, 4, 1'b0, "WXYZ", 1'b0, 0,  "WXYZ");
        vecs[4] = mk("12345",      2'b10, 5, 1'b0, "1234", 1'b1, 40, "2345");
        vecs[5] = mk("QRSTUV",     2'b11, 6, 1'b0, "QRST", 1'b1, 40, "QRST");
        vecs[6] = mk("ABCDEFGH",   2'b00, 8, 1'b0, "ABCD", 1'b1, 40, "ABCD");

        reset = 1'b1;
        bus.ascii_data = '0; bus.ascii_data_ready = 1'b0; bus.mode = 2'b00; bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_disp", bus.string_data, BLANK);
        check("rst_len",  bus.msg_len, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovf",  bus.overflow, 0);
        reset = 1'b0;
        quiet(50, BLANK, "empty");

        // Vector table
        foreach (vecs[i]) begin
            bus.mode = vecs[i].mode;
            send_frame(vecs[i].msg);
            wait_commit(cyc, d);
            check("vec_latency_ok", (cyc <= 6), 1);
            check("vec_disp0", d, vecs[i].disp0);
            check("vec_len",   bus.msg_len, vecs[i].exp_len);
            check("vec_ovf",   bus.overflow, vecs[i].exp_ovf);
            if (vecs[i].exp_step) begin
                next_step(-1, 0, dw, d);
                check("vec_dwell", dw, vecs[i].dwell1);
                check("vec_disp1", d, vecs[i].disp1);
            end else begin
                quiet(500, vecs[i].disp0, "vec_quiet");
            end
        end

        // Wrap sequence
        start_msg("ABCDEF", 2'b01, "wrap");
        run_seq("wrap", '{"BCDE", "CDEF", "ABCD"}, '{40, 20, 30});

        // Bounce sequence: positions 0,1,2,1,0,1
        start_msg("ABCDEF", 2'b10, "bounce");
        run_seq("bounce", '{"BCDE", "CDEF", "BCDE", "ABCD", "BCDE"}, '{40, 20, 30, 20, 40});

        // Pause mid-dwell at position 1
        start_msg("ABCDEF", 2'b01, "pause");
        next_step(-1, 0, dw, d);
        check("pause_pre_disp", d, "BCDE");
        next_step(5, 100, dw, d);
        check("pause_dwell", dw, 120);
        check("pause_disp",  d, "CDEF");

        // Switch to static: applies at the next tick only
        start_msg("ABCDEF", 2'b01, "static");
        next_step(-1, 0, dw, d);
        bus.mode = 2'b00;
        check("static_hold_disp", bus.string_data, "BCDE");
        run_seq("static", '{"ABCD", "ABCD"}, '{20, 40});

        // Reset in the middle of a refresh
        bus.mode = 2'b01;
        send_frame("ABCDEF");
        repeat (2) @(negedge clk);
        check("mid_refresh_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_disp", bus.string_data, BLANK);
        check("mid_rst_len",  bus.msg_len, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ovf",  bus.overflow, 0);
        reset = 1'b0;
        quiet(100, BLANK, "post_rst");

        // New frame while scrolling restarts at position 0
        start_msg("ABCDEF", 2'b01, "restart_a");
        next_step(-1, 0, dw, d);
        repeat (7) @(negedge clk);
        start_msg("MNOPQRS", 2'b01, "restart_b");
        run_seq("restart", '{"NOPQ", "OPQR"}, '{40, 20});

        // Randomized messages against the reference model
        base = "............";
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 12; i++) base.putc(i, 8'($urandom_range(33, 126)));
            len = $urandom_range(1, 12);
            s   = base.substr(0, len - 1);
            m   = 2'($urandom_range(0, 3));
            start_msg(s, m, "rnd");
            len = (len > DEPTH) ? DEPTH : len;
            check("rnd_len", bus.msg_len, len);
            check("rnd_ovf", bus.overflow, (s.len() > DEPTH));
            last = last_of(len);
            if (last == 0) begin
                quiet(60, window(s, 0), "rnd_quiet");
            end else begin
                prev = 0;
                for (int k = 1; k <= 4; k++) begin
                    pos = pos_at(m, last, k);
                    next_step(-1, 0, dw, d);
                    check("rnd_dwell", dw, limit_of(prev, last));
                    check("rnd_disp",  d, window(s, pos));
                    prev = pos;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
